// File: rtl/cover_toggle_collector_if.sv
// Valid/ready stream carrying newly covered global cover indices.
// The collector drives the master side; the uplink arbiter is the slave.
interface cover_toggle_collector_if;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_index;

    modport master (
        output out_valid,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/cover_toggle_collector.sv
// Toggle cover collector: sticky first-hit bitmap, pending queue, and an index stream out.
// Optional re-export of the whole covered map is enabled by defining COVER_TOGGLE_DRAIN_EN.
module cover_toggle_collector #(
    parameter int WIDTH       = 124,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 38253,
    parameter int CNT_W       = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         valid,
    input  logic                     clear,
`ifdef COVER_TOGGLE_DRAIN_EN
    input  logic                     drain,
    output logic                     drain_busy,
`endif
    cover_toggle_collector_if.master stream,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     all_covered
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef COVER_TOGGLE_DRAIN_EN
    typedef enum logic [0:0] {RUN, DRAIN} state_t;
`else
    typedef enum logic [0:0] {RUN} state_t;
`endif

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   covered_reg, covered_next;
    logic [WIDTH-1:0]   pending_reg, pending_next;
    logic [WIDTH-1:0]   new_hit;
    logic [WIDTH-1:0]   pend_take;
    logic               out_valid_reg, out_valid_next;
    logic [63:0]        out_index_reg, out_index_next;
    logic               drained_reg, drained_next;
    logic [CNT_W-1:0]   hit_count_reg, hit_count_next;
    logic               all_covered_reg, all_covered_next;
`ifdef COVER_TOGGLE_DRAIN_EN
    logic [IDX_W-1:0]   scan_ptr_reg, scan_ptr_next;
    logic               scan_last;
`endif

    logic               load_en;
    logic               handshake;
    logic               run_mode;
    logic               pend_found;
    logic [IDX_W-1:0]   pend_idx;
    logic               pend_load;

    assign load_en   = !out_valid_reg || stream.out_ready;
    assign handshake = out_valid_reg && stream.out_ready;
    assign run_mode  = (state_reg == RUN);
    assign pend_load = run_mode && load_en && pend_found;

    // Lowest-index pending point wins; scanning downward leaves the smallest index.
    always_comb begin
        pend_found = 1'b0;
        pend_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                pend_found = 1'b1;
                pend_idx   = IDX_W'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_point
            assign new_hit[gi]      = valid[gi] & ~covered_reg[gi];
            assign pend_take[gi]    = pend_load && (pend_idx == IDX_W'(gi));
            assign covered_next[gi] = covered_reg[gi] | valid[gi];
            assign pending_next[gi] = (pending_reg[gi] & ~pend_take[gi]) | new_hit[gi];
        end
    endgenerate

    assign all_covered_next = all_covered_reg | (&covered_reg);

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_index_next = out_index_reg;
        drained_next   = drained_reg;
        hit_count_next = hit_count_reg;
`ifdef COVER_TOGGLE_DRAIN_EN
        scan_ptr_next  = scan_ptr_reg;
        scan_last      = (scan_ptr_reg == IDX_W'(WIDTH - 1));
`endif

        // Re-exported indices were already counted on their first export.
        if (handshake && !drained_reg && (hit_count_reg != {CNT_W{1'b1}}))
            hit_count_next = hit_count_reg + 1'b1;

        // A free or emptying register drops valid unless something loads below.
        if (load_en)
            out_valid_next = 1'b0;

        case (state_reg)
            RUN: begin
                if (pend_load) begin
                    out_valid_next = 1'b1;
                    out_index_next = 64'(COVER_INDEX) + 64'(pend_idx);
                    drained_next   = 1'b0;
                end
`ifdef COVER_TOGGLE_DRAIN_EN
                if (drain) begin
                    state_next    = DRAIN;
                    scan_ptr_next = '0;
                end
`endif
            end
`ifdef COVER_TOGGLE_DRAIN_EN
            DRAIN: begin
                if (!covered_reg[scan_ptr_reg] || load_en) begin
                    if (covered_reg[scan_ptr_reg]) begin
                        out_valid_next = 1'b1;
                        out_index_next = 64'(COVER_INDEX) + 64'(scan_ptr_reg);
                        drained_next   = 1'b1;
                    end
                    if (scan_last)
                        state_next = RUN;
                    else
                        scan_ptr_next = scan_ptr_reg + 1'b1;
                end
            end
`endif
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state_reg       <= RUN;
            covered_reg     <= '0;
            pending_reg     <= '0;
            out_valid_reg   <= 1'b0;
            drained_reg     <= 1'b0;
            hit_count_reg   <= '0;
            all_covered_reg <= 1'b0;
`ifdef COVER_TOGGLE_DRAIN_EN
            scan_ptr_reg    <= '0;
`endif
            if (!reset)
                out_index_reg <= '0;
        end else begin
            state_reg       <= state_next;
            covered_reg     <= covered_next;
            pending_reg     <= pending_next;
            out_valid_reg   <= out_valid_next;
            out_index_reg   <= out_index_next;
            drained_reg     <= drained_next;
            hit_count_reg   <= hit_count_next;
            all_covered_reg <= all_covered_next;
`ifdef COVER_TOGGLE_DRAIN_EN
            scan_ptr_reg    <= scan_ptr_next;
`endif
        end
    end

    // Simulation-only sanity check on the global index window.
    always_ff @(posedge clock) begin
        if (reset)
            assert (COVER_INDEX + WIDTH <= COVER_TOTAL)
            else $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    assign stream.out_valid = out_valid_reg;
    assign stream.out_index = out_index_reg;
    assign hit_count        = hit_count_reg;
    assign all_covered      = all_covered_reg;
`ifdef COVER_TOGGLE_DRAIN_EN
    assign drain_busy       = (state_reg == DRAIN);
`endif

endmodule

// File: doc/cover_toggle_collector.md
Name: cover_toggle_collector

Overview:
- Hardware-side collector for toggle cover points: the receiving end of a per-bit toggle `valid` vector.
- Records first hits in a sticky bitmap and queues newly hit points.
- Streams their global cover indices one per cycle over a valid/ready interface, so FPGA/emulation builds export coverage without DPI.
- Sits next to each toggle-cover instance; the output stream feeds the coverage uplink arbiter.

Parameters:
WIDTH, 124, number of cover points (bits of valid)
COVER_INDEX, 0, global index of bit 0; out_index = COVER_INDEX + bit position
COVER_TOTAL, 38253, total cover points in the design; used only for the index range check
CNT_W, 16, width of hit_count (saturating)

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-low reset
valid  input  WIDTH  per-point hit strobes, sampled every cycle
clear  input  1  synchronous clear of all coverage state
out_valid  output  1  out_index holds a newly covered point
out_ready  input  1  downstream accepts out_index
out_index  output  64  global cover index
hit_count  output  CNT_W  number of indices accepted downstream, saturating
all_covered  output  1  every point's covered bit set

Behaviour:
- Reset:
  - Reset is synchronous, active-low (reset); the clock is clock.
  - While reset==0 at a rising edge: covered, pending, out_valid, out_index, hit_count and all_covered all go to 0, and the FSM goes to RUN.
  - Reset mid-transfer discards the output register and all pending points.
- State per point i:
  - covered[i] (sticky) and pending[i].
  - At an edge with valid[i]==1 and covered[i]==0: both covered[i] and pending[i] are set.
  - Repeat hits of a covered point are ignored.
- Output register:
  - Loads when out_valid==0, or when out_valid&&out_ready at the same edge (1 index/cycle throughput).
  - On load: pick the lowest-index pending bit, drive out_index = COVER_INDEX + i, set out_valid, and clear pending[i] at that same edge.
  - If nothing is pending at a handshake edge, out_valid drops to 0.
- Latency: valid[i] sampled at edge N sets pending; out_valid is visible after edge N+1 if the register is free. The pending-priority select sees only state registered before the edge.
- Handshake rules:
  - out_index and out_valid stay stable while out_valid&&!out_ready.
  - hit_count += 1 on each handshake and saturates at 2^CNT_W-1.
- Simultaneous events: valid[i] at the edge where pending[i] is loaded keeps pending[i] cleared, because covered[i] is already set. Several bits hitting in one cycle are emitted in ascending index order.
- clear:
  - At an edge with clear==1 (reset high): covered, pending, hit_count and all_covered go to 0, and out_valid goes to 0 even without a handshake.
  - valid in the same cycle is ignored.
  - clear takes priority over everything except reset.
- all_covered is registered: 1 the cycle after covered becomes all-ones, then sticky until clear or reset.
- Assertion (simulation only): COVER_INDEX+WIDTH <= COVER_TOTAL.

Optional Feature:
- Macro: COVER_TOGGLE_DRAIN_EN.
- With the macro defined:
  - Adds input drain (1 bit) and output drain_busy (1 bit).
  - FSM states RUN and DRAIN.
  - In RUN, drain==1 with clear==0 moves to DRAIN at the next edge and resets the scan pointer to 0; drain_busy is 1 in DRAIN.
  - In DRAIN, the scan pointer steps 0..WIDTH-1. Each point with covered==1 is loaded into the output register, following the same handshake rules.
  - Uncovered points are skipped at 1 per cycle.
  - pending continues to accumulate but is not emitted.
  - After pointer WIDTH-1 is processed, the FSM returns to RUN.
  - hit_count does not increment for drained indices.
  - clear or reset in DRAIN aborts to RUN.
- Without the macro: no drain/drain_busy ports, and the FSM is RUN only.

Test Plan:
1. COVER_INDEX=100, out_ready=1, pulse valid[5] for one cycle at edge N -> out_valid=1 after edge N+1 with out_index=105; hit_count=1 after the handshake; pulse valid[5] again -> no output.
2. valid=bits{3,0,7} in one cycle, out_ready=1 -> indices 100,103,107 on 3 consecutive cycles; hit_count=3.
3. out_ready=0 for 5 cycles with 2 pending -> out_index=100 held stable; raise out_ready -> 100 then 103 back-to-back.
4. Hit all 124 bits -> all_covered=1 one cycle after the last hit; hit_count=124 after draining; clear -> all_covered=0 and hit_count=0; valid[0] re-emits 100.
5. reset=0 while out_valid=1 and 10 pending -> all outputs 0 next cycle; no stale index after reset=1.
6. (COVER_TOGGLE_DRAIN_EN) cover bits 2 and 9, let them stream out, then pulse drain -> re-emits 102 and 109; drain_busy high for ≥124 cycles; hit_count unchanged at 2.
